// File: rtl/pattern_seq_detector.sv
// -----------------------------------------------------------------------------
// pattern_seq_detector
//
// Serial bit-pattern detector with a runtime-loadable pattern, selectable
// overlapping / non-overlapping detection, a saturating match counter and a
// seven-segment glyph of the counter's low nibble.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..8)
//   PATTERN  pattern value restored by reset (PAT_LEN bits)
//   CNT_W    match counter width (4..16)
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   en           global enable; when low every register holds (rst still acts)
//   bit_valid    x is presented this cycle
//   x            serial data bit
//   overlap      1 = matches may share bits, 0 = each match needs fresh bits
//   load         strobe: capture pat_in as the pattern, restart history fill
//   pat_in       new pattern value
//   clear_cnt    strobe: zero match_count (wins over a same-edge detection)
//   match        registered one-cycle detection pulse
//   match_count  registered saturating detection count
//   seg          {dp = match, g..a = hex glyph of match_count[3:0]}
// -----------------------------------------------------------------------------
module pattern_seq_detector #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1101,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               bit_valid,
  input  logic               x,
  input  logic               overlap,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clear_cnt,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [7:0]         seg
);

  // fill counts accepted bits since reset/load/non-overlapping match, 0..PAT_LEN
  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic               accept;
  logic [PAT_LEN-1:0] shifted;
  logic               detect;
  logic [6:0]         seg_glyph;

  // A bit arriving together with load is dropped.
  assign accept  = en & bit_valid & ~load;
  assign shifted = {hist_q[PAT_LEN-2:0], x};
  // The incoming bit completes a window only if PAT_LEN-1 valid bits precede it.
  assign detect  = accept && (shifted == pat_q) && (fill_q >= FILL_LAST);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    match_d = match_q;
    cnt_d   = cnt_q;

    if (en) begin
      match_d = detect;

      if (load) begin
        pat_d  = pat_in;
        fill_d = '0;
      end else if (bit_valid) begin
        hist_d = shifted;
        if (detect && !overlap) begin
          fill_d = '0;
        end else if (fill_q != FILL_MAX) begin
          fill_d = fill_q + 1'b1;
        end
      end

      if (clear_cnt) begin
        cnt_d = '0;
      end else if (detect && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PATTERN;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    seg_glyph = 7'h71;
    case (cnt_q[3:0])
      4'h0:    seg_glyph = 7'h3F;
      4'h1:    seg_glyph = 7'h06;
      4'h2:    seg_glyph = 7'h5B;
      4'h3:    seg_glyph = 7'h4F;
      4'h4:    seg_glyph = 7'h66;
      4'h5:    seg_glyph = 7'h6D;
      4'h6:    seg_glyph = 7'h7D;
      4'h7:    seg_glyph = 7'h07;
      4'h8:    seg_glyph = 7'h7F;
      4'h9:    seg_glyph = 7'h6F;
      4'hA:    seg_glyph = 7'h77;
      4'hB:    seg_glyph = 7'h7C;
      4'hC:    seg_glyph = 7'h39;
      4'hD:    seg_glyph = 7'h5E;
      4'hE:    seg_glyph = 7'h79;
      default: seg_glyph = 7'h71;
    endcase
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign seg         = {match_q, seg_glyph};

endmodule

// File: tb/tb_pattern_seq_detector.sv
module tb_pattern_seq_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, bit_valid = 1'b0, x = 1'b0;
  logic       overlap = 1'b0, load = 1'b0, clear_cnt = 1'b0;
  logic [3:0] pat_in = 4'h0;

  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;
  logic [7:0] seg_a, seg_b;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  always #5 clk = ~clk;

  pattern_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .bit_valid(bit_valid), .x(x),
    .overlap(overlap), .load(load), .pat_in(pat_in), .clear_cnt(clear_cnt),
    .match(match_a), .match_count(cnt_a), .seg(seg_a)
  );

  pattern_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .bit_valid(bit_valid), .x(x),
    .overlap(overlap), .load(load), .pat_in(pat_in), .clear_cnt(clear_cnt),
    .match(match_b), .match_count(cnt_b), .seg(seg_b)
  );

  // Reference model: queue of bits accepted since the last reset, load or
  // non-overlapping match; a match needs 4 such bits whose last 4 equal pat.
  bit         fresh[$];
  logic [3:0] m_pat   = 4'b1101;
  logic       m_match = 1'b0;
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, e, bv, xx, ov, ld,
                            input logic [3:0] pin, input logic clr);
    int  val;
    bit  det;
    if (r) begin
      fresh.delete();
      m_pat   = 4'b1101;
      m_match = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (e) begin
      det = 1'b0;
      if (ld) begin
        m_pat = pin;
        fresh.delete();
      end else if (bv) begin
        fresh.push_back(xx);
        if (fresh.size() >= 4) begin
          val = 0;
          for (int i = fresh.size() - 4; i < fresh.size(); i++)
            val = (val << 1) | int'(fresh[i]);
          det = (val == int'(m_pat));
        end
        if (det && !ov) fresh.delete();
        while (fresh.size() > 4) void'(fresh.pop_front());
      end
      m_match = det;
      if (clr) begin
        m_cnt_a = 0;
        m_cnt_b = 0;
      end else if (det) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 15)  m_cnt_b++;
      end
    end
  endtask

  task automatic cyc(input logic r, e, bv, xx, ov, ld,
                     input logic [3:0] pin, input logic clr);
    @(negedge clk);
    rst = r; en = e; bit_valid = bv; x = xx; overlap = ov;
    load = ld; pat_in = pin; clear_cnt = clr;
    model_step(r, e, bv, xx, ov, ld, pin, clr);
    @(posedge clk);
    #1;
    chk("match_a", 16'(match_a), 16'(m_match));
    chk("cnt_a",   16'(cnt_a),   16'(m_cnt_a));
    chk("seg_a",   16'(seg_a),   16'({m_match, glyph[m_cnt_a % 16]}));
    chk("match_b", 16'(match_b), 16'(m_match));
    chk("cnt_b",   16'(cnt_b),   16'(m_cnt_b));
    chk("seg_b",   16'(seg_b),   16'({m_match, glyph[m_cnt_b % 16]}));
  endtask

  task automatic bitin(input logic b, input logic ov);
    cyc(1'b0, 1'b1, 1'b1, b, ov, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle(input logic ov);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ov, 1'b0, 4'h0, 1'b0);
  endtask

  // Reset with every other control active: reset must still win.
  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
  endtask

  logic [6:0] stream = 7'b1101101;

  initial begin
    // Reset state
    phase = "reset";
    do_reset();
    chk("seg_after_reset", 16'(seg_a), 16'h3F);
    chk("cnt_after_reset", 16'(cnt_a), 16'h0);

    // Overlapping detection: matches after bits 4 and 7
    phase = "overlap";
    for (int i = 6; i >= 0; i--) begin
      bitin(stream[i], 1'b1);
      if (i == 3) chk("match_bit4", 16'(match_a), 16'h1);
    end
    chk("match_bit7", 16'(match_a), 16'h1);
    chk("seg_pulse", 16'(seg_a), 16'hDB);
    idle(1'b1);
    chk("cnt_final", 16'(cnt_a), 16'h2);
    chk("seg_idle", 16'(seg_a), 16'h5B);

    // Non-overlapping detection: a single match after bit 4
    phase = "nonoverlap";
    do_reset();
    for (int i = 6; i >= 0; i--) bitin(stream[i], 1'b0);
    idle(1'b0);
    chk("cnt_final", 16'(cnt_a), 16'h1);
    chk("seg_idle", 16'(seg_a), 16'h06);

    // Gaps in bit_valid and en must not disturb the stream
    phase = "gap_en";
    do_reset();
    bitin(1'b1, 1'b1);
    bitin(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1);
    bitin(1'b0, 1'b1);
    chk("no_early_match", 16'(match_a), 16'h0);
    bitin(1'b1, 1'b1);
    chk("match_bit4", 16'(match_a), 16'h1);
    idle(1'b1);
    chk("cnt_final", 16'(cnt_a), 16'h1);

    // Load drops the coincident bit; 0000 needs four fresh zeros
    phase = "load";
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0);
    chk("match_on_load", 16'(match_a), 16'h0);
    for (int i = 0; i < 3; i++) begin
      bitin(1'b0, 1'b1);
      chk("no_early_match", 16'(match_a), 16'h0);
    end
    bitin(1'b0, 1'b1);
    chk("match_4th_zero", 16'(match_a), 16'h1);

    // Saturation of the 4-bit counter, then clear against a detection
    phase = "saturate";
    do_reset();
    bitin(1'b1, 1'b1); bitin(1'b1, 1'b1); bitin(1'b0, 1'b1); bitin(1'b1, 1'b1);
    for (int n = 0; n < 19; n++) begin
      bitin(1'b1, 1'b1); bitin(1'b0, 1'b1); bitin(1'b1, 1'b1);
    end
    idle(1'b1);
    chk("cnt_b_sat", 16'(cnt_b), 16'hF);
    chk("seg_b_sat", 16'(seg_b), 16'h71);
    chk("cnt_a_20", 16'(cnt_a), 16'd20);
    bitin(1'b1, 1'b1);
    bitin(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("clear_match", 16'(match_b), 16'h1);
    chk("clear_cnt_b", 16'(cnt_b), 16'h0);

    // Mid-stream reset discards history
    phase = "midreset";
    do_reset();
    bitin(1'b1, 1'b1); bitin(1'b1, 1'b1); bitin(1'b0, 1'b1);
    do_reset();
    bitin(1'b1, 1'b1);
    chk("no_match_after_reset", 16'(match_a), 16'h0);
    bitin(1'b1, 1'b1); bitin(1'b0, 1'b1);
    chk("still_no_match", 16'(match_a), 16'h0);
    bitin(1'b1, 1'b1);
    chk("match_4_new_bits", 16'(match_a), 16'h1);

    // Randomized traffic against the reference model
    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 9) < 7),
          1'($urandom),
          1'($urandom),
          1'($urandom_range(0, 39) == 0),
          4'($urandom),
          1'($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_seq_detector.md
PATTERN_SEQ_DETECTOR -- requirements
Module: pattern_seq_detector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter PAT_LEN, default 4, SHALL set the pattern length in bits; the legal range is 2..8.
REQ-003 Parameter PATTERN, default 4'b1101, SHALL be the pattern value after reset; it is PAT_LEN bits wide.
REQ-004 Parameter CNT_W, default 8, SHALL set the match counter width; the legal range is 4..16.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port en, input, 1 bit: global enable; while low, all state SHALL hold, except that rst still acts.
REQ-008 Port bit_valid, input, 1 bit: when high, x SHALL be accepted in this cycle.
REQ-009 Port x, input, 1 bit: serial data bit.
REQ-010 Port overlap, input, 1 bit: 1 selects overlapping detection; 0 selects non-overlapping detection.
REQ-011 Port load, input, 1 bit: one-cycle strobe that captures pat_in as the new pattern.
REQ-012 Port pat_in, input, PAT_LEN bits: new pattern value.
REQ-013 Port clear_cnt, input, 1 bit: one-cycle strobe that zeroes match_count.
REQ-014 Port match, output, 1 bit: registered, one-cycle pulse per detection.
REQ-015 Port match_count, output, CNT_W bits: registered, saturating count of detections.
REQ-016 Port seg, output, 8 bits: seven-segment drive, with bit0..bit6 = segments a..g and bit7 = dp, all active-high.

Function
REQ-017 The block SHALL hold the history register hist[PAT_LEN-1:0], the fill counter fill (0..PAT_LEN), and the pattern register pat[PAT_LEN-1:0].
REQ-018 A bit SHALL be accepted when en=1, bit_valid=1 and load=0.
REQ-019 On an accepted bit: hist <= {hist[PAT_LEN-2:0], x}, so the first-received bit ends up as the MSB; fill SHALL increment and saturate at PAT_LEN.
REQ-020 Detection condition: an accepted bit where {hist[PAT_LEN-2:0], x} == pat and (fill+1) >= PAT_LEN, with fill taken before the increment.
REQ-021 On detection, match SHALL be 1 in the cycle after the accepted edge; otherwise match SHALL be 0, so latency is exactly 1 clock.
REQ-022 Overlap=1: hist and fill SHALL be retained after a detection, so bits may be shared between matches.
REQ-023 Overlap=0: on a detection edge, fill SHALL become 0, so the next match needs PAT_LEN fresh bits; hist may take the shifted value.
REQ-024 Overlap SHALL be sampled per accepted bit; a change mid-stream SHALL affect only subsequent detections.
REQ-025 On load=1 with en=1: pat <= pat_in and fill <= 0; match_count SHALL be unchanged; match SHALL be 0 in the next cycle.
REQ-026 A bit presented in the same cycle as load SHALL be discarded.
REQ-027 On a detection edge, match_count SHALL increment by 1 and saturate at 2^CNT_W-1, with no wrap.
REQ-028 On clear_cnt=1 with en=1, match_count SHALL become 0; if a detection occurs in the same edge, clear SHALL win (count=0) while match still pulses.
REQ-029 seg[6:0] SHALL be the combinational hex glyph of match_count[3:0]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-030 seg[7] SHALL equal match.

Reset
REQ-031 While rst=1 at a clock edge: hist=0, fill=0, pat=PATTERN, match=0, match_count=0; regardless of en, load or bit_valid.
REQ-032 After reset, seg SHALL read 8'h3F.
REQ-033 Reset asserted mid-stream SHALL discard partial history, so no match can complete using bits accepted before reset.

Verification
REQ-034 Overlap test: defaults, overlap=1, stream 1,1,0,1,1,0,1 (one bit/cycle) -> match after bits 4 and 7; match_count=2; seg=8'h5B idle and 8'hDB during the pulse.
REQ-035 Non-overlap test: same stream, overlap=0 -> single match after bit 4; match_count=1; seg=8'h06.
REQ-036 Gap/enable test: stream 1,1,0,1 with bit_valid low for 3 cycles between bits 2 and 3, plus en low for 2 cycles -> exactly one match, 1 cycle after bit 4.
REQ-037 Load test: load with pat_in=4'b0000 while bit_valid=1 and x=1 -> bit dropped; then four 0s -> match after the 4th 0 only, not earlier.
REQ-038 Saturation/clear test: CNT_W=4, 20 matches -> match_count holds at 15 (seg=8'h71); clear_cnt coincident with a detection -> count 0, match=1.
REQ-039 Reset test: rst pulsed after bits 1,1,0 then a single 1 -> no match; the full pattern then needs 4 new bits.
